// File: rtl/down_counter_sync_tff_if.sv
// Control/status bundle for the loadable T-FF down counter.
// The controller side (master) loads and enables; the counter side (slave) reports count and status.
interface down_counter_sync_tff_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, en, auto_reload,
        input  q, busy, done
    );

    modport slave (
        input  load, load_val, en, auto_reload,
        output q, busy, done
    );
endinterface

// File: rtl/down_counter_sync_tff.sv
// Loadable synchronous down counter built from T flip-flops, used as an interval timer
// with a one-cycle done pulse on expiry and an optional auto-reload (periodic tick) mode.
module down_counter_sync_tff #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    down_counter_sync_tff_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] reload_reg, reload_nxt;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] t_dec;
    logic             done, done_nxt;

    // Borrow ripple: bit i toggles when every lower bit is already zero.
    always_comb begin
        t_dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_dec[i] = ~|(q & ((WIDTH'(1) << i) - WIDTH'(1)));
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt  = state;
        reload_nxt = reload_reg;
        done_nxt   = 1'b0;
        t          = '0;

        if (bus.load) begin
            t          = q ^ bus.load_val;
            reload_nxt = bus.load_val;
            state_nxt  = (bus.load_val != '0) ? COUNT : IDLE;
        end else if (state == COUNT && bus.en) begin
            if (q == WIDTH'(1)) begin
                done_nxt = 1'b1;
                if (bus.auto_reload) begin
                    t = q ^ reload_reg;
                end else begin
                    t         = q;
                    state_nxt = IDLE;
                end
            end else if (q != '0) begin
                t = t_dec;
            end else begin
                // Unreachable in normal use; refuse to wrap and fall back to IDLE.
                state_nxt = IDLE;
            end
        end
    end

    // NOTE: state elements use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q          <= '0;
            reload_reg <= '0;
            state      <= IDLE;
            done       <= 1'b0;
        end else begin
            q          <= q ^ t;
            reload_reg <= reload_nxt;
            state      <= state_nxt;
            done       <= done_nxt;
        end
    end

    assign bus.q    = q;
    assign bus.busy = (state == COUNT);
    assign bus.done = done;

endmodule

// File: tb/tb_down_counter_sync_tff.sv
// Self-checking bench for down_counter_sync_tff: directed vectors with literal expectations
// plus a cycle-by-cycle comparison against an arithmetic model of the counter's rules.
module tb_down_counter_sync_tff;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    down_counter_sync_tff_if #(.WIDTH(WIDTH)) bus ();

    down_counter_sync_tff #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic model: count value, reload value and a running flag, nothing more.
    logic [WIDTH-1:0] m_q, m_rel;
    logic             m_run, m_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q    <= '0;
            m_rel  <= '0;
            m_run  <= 1'b0;
            m_done <= 1'b0;
        end else if (bus.load) begin
            m_q    <= bus.load_val;
            m_rel  <= bus.load_val;
            m_run  <= (bus.load_val != 0);
            m_done <= 1'b0;
        end else if (m_run && bus.en && m_q == 1) begin
            m_done <= 1'b1;
            m_q    <= bus.auto_reload ? m_rel : '0;
            m_run  <= bus.auto_reload;
        end else if (m_run && bus.en) begin
            m_q    <= m_q - 1;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_q", 32'(bus.q), 32'(m_q));
            check("model_busy", 32'(bus.busy), 32'(m_run));
            check("model_done", 32'(bus.done), 32'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic [WIDTH-1:0] v, input logic e, input logic a);
        bus.load        = l;
        bus.load_val    = v;
        bus.en          = e;
        bus.auto_reload = a;
    endtask

    task automatic step(input string name, input logic [WIDTH-1:0] exp_q, input logic exp_done);
        tick();
        check({name, "_q"}, 32'(bus.q), 32'(exp_q));
        check({name, "_done"}, 32'(bus.done), 32'(exp_done));
    endtask

    logic [WIDTH-1:0] ar_q [9] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int pulses;
        drive(1'b0, '0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("reset_q", 32'(bus.q), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        tick();
        rst    = 1'b1;
        cmp_on = 1'b1;

        // One-shot from 3
        drive(1'b1, 4'd3, 1'b1, 1'b0);
        step("os_load", 4'd3, 1'b0);
        check("os_busy_on", 32'(bus.busy), 32'd1);
        drive(1'b0, 4'd3, 1'b1, 1'b0);
        step("os_2", 4'd2, 1'b0);
        step("os_1", 4'd1, 1'b0);
        step("os_0", 4'd0, 1'b1);
        check("os_busy_off", 32'(bus.busy), 32'd0);
        step("os_hold", 4'd0, 1'b0);

        // Auto-reload period 3
        drive(1'b1, 4'd3, 1'b1, 1'b1);
        step("ar_load", 4'd3, 1'b0);
        drive(1'b0, 4'd3, 1'b1, 1'b1);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("ar_q", 32'(bus.q), 32'(ar_q[i]));
            pulses += int'(bus.done);
        end
        check("ar_pulses", 32'(pulses), 32'd3);

        // Enable gating
        drive(1'b1, 4'd5, 1'b0, 1'b0);
        step("en_load", 4'd5, 1'b0);
        drive(1'b0, 4'd5, 1'b1, 1'b0);
        step("en_1", 4'd4, 1'b0);
        drive(1'b0, 4'd5, 1'b0, 1'b0);
        step("en_0a", 4'd4, 1'b0);
        step("en_0b", 4'd4, 1'b0);
        drive(1'b0, 4'd5, 1'b1, 1'b0);
        step("en_1b", 4'd3, 1'b0);

        // Asynchronous reset mid-count at q=5
        drive(1'b1, 4'd7, 1'b1, 1'b0);
        step("rc_load", 4'd7, 1'b0);
        drive(1'b0, 4'd7, 1'b1, 1'b0);
        step("rc_6", 4'd6, 1'b0);
        step("rc_5", 4'd5, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("rc_async_q", 32'(bus.q), 32'd0);
        check("rc_async_busy", 32'(bus.busy), 32'd0);
        check("rc_async_done", 32'(bus.done), 32'd0);
        tick();
        rst = 1'b1;
        step("rc_after_a", 4'd0, 1'b0);
        step("rc_after_b", 4'd0, 1'b0);
        check("rc_busy", 32'(bus.busy), 32'd0);

        // Load priority over expiry, and load of zero
        drive(1'b1, 4'd2, 1'b1, 1'b0);
        step("lp_load", 4'd2, 1'b0);
        drive(1'b0, 4'd2, 1'b1, 1'b0);
        step("lp_1", 4'd1, 1'b0);
        drive(1'b1, 4'd9, 1'b1, 1'b0);
        step("lp_9", 4'd9, 1'b0);
        check("lp_busy", 32'(bus.busy), 32'd1);
        drive(1'b1, 4'd0, 1'b1, 1'b0);
        step("lp_zero", 4'd0, 1'b0);
        check("lp_zero_busy", 32'(bus.busy), 32'd0);
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        step("idle_no_wrap", 4'd0, 1'b0);

        // Full scale: F down to 0 through every borrow pattern
        drive(1'b1, 4'hF, 1'b1, 1'b0);
        step("fs_load", 4'hF, 1'b0);
        drive(1'b0, 4'hF, 1'b1, 1'b0);
        pulses = 0;
        for (int i = 14; i >= 0; i--) begin
            tick();
            check("fs_q", 32'(bus.q), 32'(i));
            pulses += int'(bus.done);
        end
        check("fs_pulses", 32'(pulses), 32'd1);
        step("fs_hold", 4'd0, 1'b0);

        // Reload value 1: done on every enabled cycle, q never leaves 1
        drive(1'b1, 4'd1, 1'b1, 1'b1);
        step("r1_load", 4'd1, 1'b0);
        drive(1'b0, 4'd1, 1'b1, 1'b1);
        step("r1_a", 4'd1, 1'b1);
        step("r1_b", 4'd1, 1'b1);
        step("r1_c", 4'd1, 1'b1);
        drive(1'b0, 4'd1, 1'b0, 1'b1);
        step("r1_hold", 4'd1, 1'b0);

        // auto_reload dropped mid-count takes effect at expiry
        drive(1'b1, 4'd2, 1'b1, 1'b1);
        step("ac_load", 4'd2, 1'b0);
        drive(1'b0, 4'd2, 1'b1, 1'b1);
        step("ac_1", 4'd1, 1'b0);
        drive(1'b0, 4'd2, 1'b1, 1'b0);
        step("ac_0", 4'd0, 1'b1);
        check("ac_busy", 32'(bus.busy), 32'd0);

        @(negedge clk);
        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
